// File: rtl/risk_pkg.sv
// Shared types and constants for the risk alarm controller: alarm levels,
// persistence direction tags and the input clamp helper.
package risk_pkg;

  typedef enum logic [1:0] {
    SAFE  = 2'd0,
    WATCH = 2'd1,
    WARN  = 2'd2,
    ALERT = 2'd3
  } level_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  localparam logic [7:0] RISK_MAX   = 8'd100;
  localparam logic [7:0] COUNT_MAX  = 8'd255;
  localparam int         NUM_LEVELS = 4;

  // Fuzzy stage nominally stays within 0..100; anything above is pinned.
  function automatic logic [7:0] clamp_risk(input logic [7:0] raw);
    return (raw > RISK_MAX) ? RISK_MAX : raw;
  endfunction

endpackage

// File: rtl/risk_persist_cnt.sv
// Debounce counter: fires once PERSIST consecutive valid samples have carried
// the same transition request (direction and target level).
module risk_persist_cnt
  import risk_pkg::*;
#(
  parameter int PERSIST = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   valid,
  input  dir_t   req_dir,
  input  level_t req_tgt,
  output logic   fire,
  output dir_t   fire_dir,
  output level_t fire_tgt
);

  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  logic [3:0] cnt_reg, cnt_next, cnt_inc;
  dir_t       dir_reg, dir_next;
  level_t     tgt_reg, tgt_next;

  always_comb begin
    cnt_next = cnt_reg;
    dir_next = dir_reg;
    tgt_next = tgt_reg;
    cnt_inc  = 4'd0;
    fire     = 1'b0;
    fire_dir = DIR_NONE;
    fire_tgt = SAFE;
    if (valid) begin
      if (req_dir == DIR_NONE) begin
        cnt_next = 4'd0;
        dir_next = DIR_NONE;
        tgt_next = SAFE;
      end else begin
        // A changed target restarts the run even if the direction is unchanged.
        if (req_dir == dir_reg && req_tgt == tgt_reg) begin
          cnt_inc = cnt_reg + 4'd1;
        end else begin
          cnt_inc = 4'd1;
        end
        if (cnt_inc == PERSIST_C) begin
          fire     = 1'b1;
          fire_dir = req_dir;
          fire_tgt = req_tgt;
          cnt_next = 4'd0;
          dir_next = DIR_NONE;
          tgt_next = SAFE;
        end else begin
          cnt_next = cnt_inc;
          dir_next = req_dir;
          tgt_next = req_tgt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 4'd0;
      dir_reg <= DIR_NONE;
      tgt_reg <= SAFE;
    end else begin
      cnt_reg <= cnt_next;
      dir_reg <= dir_next;
      tgt_reg <= tgt_next;
    end
  end

endmodule

// File: rtl/risk_alarm_ctrl.sv
// Four-level hysteresis alarm driven by the fuzzy risk byte, with sticky
// ALERT latch, peak-risk tracker and saturating ALERT-entry counter.
module risk_alarm_ctrl
  import risk_pkg::*;
#(
  parameter int WATCH_ON  = 30,
  parameter int WATCH_OFF = 20,
  parameter int WARN_ON   = 50,
  parameter int WARN_OFF  = 40,
  parameter int ALERT_ON  = 75,
  parameter int ALERT_OFF = 65,
  parameter int PERSIST   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] risk,
  input  logic       ack,
  output logic [1:0] level,
  output logic       alarm,
  output logic       alert_latched,
  output logic [7:0] risk_peak,
  output logic [7:0] alert_count
);

  // Threshold tables indexed by level; slot 0 (SAFE) is never used.
  localparam logic [31:0] ON_VEC  = {8'(ALERT_ON),  8'(WARN_ON),  8'(WATCH_ON),  8'd0};
  localparam logic [31:0] OFF_VEC = {8'(ALERT_OFF), 8'(WARN_OFF), 8'(WATCH_OFF), 8'd0};

  logic [7:0] r;
  logic [NUM_LEVELS-1:0] on_hit;
  logic [NUM_LEVELS-1:0] off_hit;

  level_t level_reg, level_next;
  logic   latched_reg, latched_next;
  logic [7:0] peak_reg, peak_next, peak_base;
  logic [7:0] count_reg, count_next;

  dir_t   req_dir;
  level_t req_tgt;
  logic   fire;
  dir_t   fire_dir;
  level_t fire_tgt;
  logic   alert_entry;
  logic   ack_eff;

  assign r = clamp_risk(risk);

  assign on_hit[0]  = 1'b0;
  assign off_hit[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_LEVELS; gi++) begin : g_thr
      assign on_hit[gi]  = (r >= ON_VEC[gi*8 +: 8]);
      assign off_hit[gi] = (r <  OFF_VEC[gi*8 +: 8]);
    end
  endgenerate

  // Up requests scan ascending so the highest qualifying level wins;
  // a step-down is only considered when nothing qualifies upward.
  always_comb begin
    req_dir = DIR_NONE;
    req_tgt = SAFE;
    for (int i = 1; i < NUM_LEVELS; i++) begin
      if (on_hit[i] && (2'(i) > level_reg)) begin
        req_dir = DIR_UP;
        req_tgt = level_t'(2'(i));
      end
    end
    if (req_dir == DIR_NONE && level_reg != SAFE && off_hit[level_reg]) begin
      req_dir = DIR_DN;
      req_tgt = level_t'(level_reg - 2'd1);
    end
  end

  risk_persist_cnt #(
    .PERSIST (PERSIST)
  ) u_persist (
    .clk      (clk),
    .rst      (rst),
    .valid    (sample_valid),
    .req_dir  (req_dir),
    .req_tgt  (req_tgt),
    .fire     (fire),
    .fire_dir (fire_dir),
    .fire_tgt (fire_tgt)
  );

  always_comb begin
    level_next = level_reg;
    if (fire) begin
      if (fire_dir == DIR_UP) begin
        level_next = fire_tgt;
      end else begin
        level_next = level_t'(level_reg - 2'd1);
      end
    end
  end

  assign alert_entry = (level_next == ALERT) && (level_reg != ALERT);
  assign ack_eff     = ack && (level_reg != ALERT);

  // ALERT entry outranks a coincident ack; the ack cycle's sample still counts toward peak.
  always_comb begin
    latched_next = latched_reg;
    if (alert_entry) begin
      latched_next = 1'b1;
    end else if (ack_eff) begin
      latched_next = 1'b0;
    end
    peak_base = ack_eff ? 8'd0 : peak_reg;
    peak_next = (sample_valid && r > peak_base) ? r : peak_base;
    count_next = count_reg;
    if (alert_entry && count_reg != COUNT_MAX) begin
      count_next = count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg   <= SAFE;
      latched_reg <= 1'b0;
      peak_reg    <= 8'd0;
      count_reg   <= 8'd0;
    end else begin
      level_reg   <= level_next;
      latched_reg <= latched_next;
      peak_reg    <= peak_next;
      count_reg   <= count_next;
    end
  end

  assign level         = level_reg;
  assign alarm         = (level_reg >= WARN);
  assign alert_latched = latched_reg;
  assign risk_peak     = peak_reg;
  assign alert_count   = count_reg;

endmodule

// File: tb/tb_risk_alarm_ctrl.sv
// Self-checking bench for risk_alarm_ctrl: directed scenarios plus a
// randomized run against a run-length reference model.
module tb_risk_alarm_ctrl;

  localparam int PERSIST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] risk = 8'd0;
  logic       ack = 1'b0;
  logic [1:0] level;
  logic       alarm;
  logic       alert_latched;
  logic [7:0] risk_peak;
  logic [7:0] alert_count;

  int n_cmp = 0;
  int n_err = 0;

  int on_thr[4]  = '{0, 30, 50, 75};
  int off_thr[4] = '{0, 20, 40, 65};

  // Reference model state: level, length of the current identical-request run.
  int m_level, m_run, m_req, m_latched, m_peak, m_count;

  always #5 clk = ~clk;

  risk_alarm_ctrl #(
    .WATCH_ON (30), .WATCH_OFF (20),
    .WARN_ON  (50), .WARN_OFF  (40),
    .ALERT_ON (75), .ALERT_OFF (65),
    .PERSIST  (PERSIST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .risk          (risk),
    .ack           (ack),
    .level         (level),
    .alarm         (alarm),
    .alert_latched (alert_latched),
    .risk_peak     (risk_peak),
    .alert_count   (alert_count)
  );

  task automatic model_reset();
    m_level = 0; m_run = 0; m_req = 0; m_latched = 0; m_peak = 0; m_count = 0;
  endtask

  // Request code: 0 none, 10+L step up to level L, 20 step down.
  task automatic model_step(input bit v, input int rk, input bit a);
    int r, req, prev;
    r = (rk > 100) ? 100 : rk;
    prev = m_level;
    if (v) begin
      req = 0;
      for (int lv = m_level + 1; lv <= 3; lv++) if (r >= on_thr[lv]) req = 10 + lv;
      if (req == 0 && m_level > 0 && r < off_thr[m_level]) req = 20;
      if (req == 0) m_run = 0;
      else if (req == m_req) m_run++;
      else m_run = 1;
      m_req = req;
      if (m_run == PERSIST) begin
        m_level = (req == 20) ? m_level - 1 : req - 10;
        m_run = 0;
        m_req = 0;
      end
    end
    if (a && prev != 3) begin
      m_latched = 0;
      m_peak = 0;
    end
    if (v && r > m_peak) m_peak = r;
    if (m_level == 3 && prev != 3) begin
      m_latched = 1;
      if (m_count < 255) m_count++;
    end
  endtask

  task automatic cyc(input bit v, input int rk, input bit a);
    sample_valid = v;
    risk = rk[7:0];
    ack = a;
    @(posedge clk);
    model_step(v, rk, a);
    #1;
    sample_valid = 1'b0;
    ack = 1'b0;
    $display("txn v=%0d risk=%0d ack=%0d -> level=%0d latched=%0d peak=%0d count=%0d",
             v, rk, a, level, alert_latched, risk_peak, alert_count);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL reset_alarm got %0d want 0", alarm); end
    n_cmp++; if (alert_latched !== 1'b0) begin n_err++; $display("FAIL reset_latched got %0d want 0", alert_latched); end
    n_cmp++; if (risk_peak !== 8'd0) begin n_err++; $display("FAIL reset_peak got %0d want 0", risk_peak); end
    n_cmp++; if (alert_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", alert_count); end
  endtask

  task automatic test_watch();
    for (int i = 0; i < 3; i++) cyc(1, 35, 0);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL watch_early got %0d want 0", level); end
    cyc(1, 35, 0);
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL watch_level got %0d want 1", level); end
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL watch_alarm got %0d want 0", alarm); end
    n_cmp++; if (risk_peak !== 8'd35) begin n_err++; $display("FAIL watch_peak got %0d want 35", risk_peak); end
  endtask

  task automatic test_jump();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 80, 0);
    cyc(1, 10, 0);
    for (int i = 0; i < 3; i++) cyc(1, 80, 0);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL jump_restart got %0d want 0", level); end
    cyc(1, 80, 0);
    n_cmp++; if (level !== 2'd3) begin n_err++; $display("FAIL jump_level got %0d want 3", level); end
    n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL jump_alarm got %0d want 1", alarm); end
    n_cmp++; if (alert_latched !== 1'b1) begin n_err++; $display("FAIL jump_latched got %0d want 1", alert_latched); end
    n_cmp++; if (alert_count !== 8'd1) begin n_err++; $display("FAIL jump_count got %0d want 1", alert_count); end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 10; i++) cyc(1, 70, 0);
    n_cmp++; if (level !== 2'd3) begin n_err++; $display("FAIL hyst_hold got %0d want 3", level); end
    for (int i = 0; i < 4; i++) cyc(1, 60, 0);
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL hyst_down got %0d want 2", level); end
    for (int i = 0; i < 4; i++) cyc(1, 45, 0);
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL hyst_warn_hold got %0d want 2", level); end
    n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL hyst_alarm got %0d want 1", alarm); end
  endtask

  task automatic test_ack();
    cyc(0, 0, 1);
    n_cmp++; if (alert_latched !== 1'b0) begin n_err++; $display("FAIL ack_warn_latched got %0d want 0", alert_latched); end
    n_cmp++; if (risk_peak !== 8'd0) begin n_err++; $display("FAIL ack_warn_peak got %0d want 0", risk_peak); end
    for (int i = 0; i < 4; i++) cyc(1, 80, 0);
    cyc(0, 0, 1);
    n_cmp++; if (alert_latched !== 1'b1) begin n_err++; $display("FAIL ack_alert_latched got %0d want 1", alert_latched); end
    n_cmp++; if (risk_peak !== 8'd80) begin n_err++; $display("FAIL ack_alert_peak got %0d want 80", risk_peak); end
    for (int i = 0; i < 4; i++) cyc(1, 60, 0);
    cyc(0, 0, 1);
    n_cmp++; if (alert_latched !== 1'b0) begin n_err++; $display("FAIL ack_clear2 got %0d want 0", alert_latched); end
    for (int i = 0; i < 3; i++) cyc(1, 80, 0);
    cyc(1, 80, 1);
    n_cmp++; if (level !== 2'd3) begin n_err++; $display("FAIL ack_entry_level got %0d want 3", level); end
    n_cmp++; if (alert_latched !== 1'b1) begin n_err++; $display("FAIL ack_entry_latched got %0d want 1", alert_latched); end
    n_cmp++; if (alert_count !== 8'd3) begin n_err++; $display("FAIL ack_entry_count got %0d want 3", alert_count); end
    n_cmp++; if (risk_peak !== 8'd80) begin n_err++; $display("FAIL ack_entry_peak got %0d want 80", risk_peak); end
  endtask

  task automatic test_clamp_and_gaps();
    do_reset();
    cyc(1, 200, 0);
    cyc(1, 200, 0);
    for (int i = 0; i < 3; i++) cyc(0, $urandom_range(0, 255), 0);
    cyc(1, 200, 0);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL gap_hold got %0d want 0", level); end
    n_cmp++; if (risk_peak !== 8'd100) begin n_err++; $display("FAIL clamp_peak got %0d want 100", risk_peak); end
    cyc(1, 200, 0);
    n_cmp++; if (level !== 2'd3) begin n_err++; $display("FAIL clamp_alert got %0d want 3", level); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int e = 0; e < 256; e++) begin
      for (int i = 0; i < 4; i++) cyc(1, 100, 0);
      for (int i = 0; i < 4; i++) cyc(1, 60, 0);
    end
    n_cmp++; if (alert_count !== 8'd255) begin n_err++; $display("FAIL sat_count got %0d want 255", alert_count); end
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL sat_level got %0d want 2", level); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 35, 0);
    do_reset();
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL rstmid_level got %0d want 0", level); end
    n_cmp++; if (risk_peak !== 8'd0) begin n_err++; $display("FAIL rstmid_peak got %0d want 0", risk_peak); end
    cyc(1, 35, 0);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL rstmid_nofire got %0d want 0", level); end
    for (int i = 0; i < 3; i++) cyc(1, 35, 0);
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL rstmid_refire got %0d want 1", level); end
  endtask

  task automatic test_random();
    bit v, a;
    int rk;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 15) == 0);
      rk = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 110);
      cyc(v, rk, a);
      n_cmp++; if (level !== 2'(m_level)) begin n_err++; $display("FAIL rnd_level n=%0d got %0d want %0d", n, level, m_level); end
      n_cmp++; if (alarm !== (m_level >= 2)) begin n_err++; $display("FAIL rnd_alarm n=%0d got %0d want %0d", n, alarm, m_level >= 2); end
      n_cmp++; if (alert_latched !== 1'(m_latched)) begin n_err++; $display("FAIL rnd_latched n=%0d got %0d want %0d", n, alert_latched, m_latched); end
      n_cmp++; if (risk_peak !== 8'(m_peak)) begin n_err++; $display("FAIL rnd_peak n=%0d got %0d want %0d", n, risk_peak, m_peak); end
      n_cmp++; if (alert_count !== 8'(m_count)) begin n_err++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, alert_count, m_count); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_watch();
    test_jump();
    test_hysteresis();
    test_ack();
    test_clamp_and_gaps();
    test_saturate();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
